pipe_execute_stage: RTL and testbench

//  Width-parametrised Y86 pipeline Execute stage. Sits between the D->E and E->M pipeline registers.

---
 rtl/y86_pkg.sv | 55 +++++
 rtl/y86_cond_eval.sv | 32 +++
 rtl/pipe_execute_stage.sv | 213 +++++++++++++++++++++
 tb/tb_pipe_execute_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 encodings: instruction and function codes, one-hot status
// codes, condition-code bit positions and the multiplier FSM states.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;  // also CMOVxx
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // OPQ function codes
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;
    localparam logic [3:0] ALU_MUL = 4'h4;

    // Jump / conditional-move function codes
    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    // One-hot status {AOK,HLT,ADR,INS}
    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] STAT_HLT = 4'b0100;
    localparam logic [3:0] STAT_ADR = 4'b0010;
    localparam logic [3:0] STAT_INS = 4'b0001;

    localparam logic [3:0] RNONE = 4'hF;

    // Condition-code layout {ZF,SF,OF}
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;
    localparam logic [2:0] CC_RESET = 3'b100;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/y86_cond_eval.sv
// Evaluates a jump / conditional-move condition against a CC value.
// Kept separate so branch prediction/recovery logic can reuse it.
module y86_cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic [2:0] cc,
    output logic       cnd
);

    logic zf, sf, of;

    assign zf = cc[CC_ZF];
    assign sf = cc[CC_SF];
    assign of = cc[CC_OF];

    // Condition decode; unknown function codes are never taken
    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = (sf ^ of) | zf;
            C_L:     cnd = sf ^ of;
            C_E:     cnd = zf;
            C_NE:    cnd = ~zf;
            C_GE:    cnd = ~(sf ^ of);
            C_G:     cnd = ~(sf ^ of) & ~zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipe_execute_stage.sv
// Y86 pipeline Execute stage: ALU, condition-code register, condition
// evaluation, and the E->M pipeline register.
// Optional feature macro MULQ_EN: adds OPQ ifun 4 (MUL) as an iterative
// shift-add multiplier, one bit per clock, which stalls upstream via
// execute_busy. Without it, ifun 4 is an invalid ALU function.
//
// E->M register control, highest priority first:
//   rst       -> bubble contents, asynchronously
//   M_bubble  -> load a NOP (wins over M_stall)
//   M_stall   -> hold current contents
//   busy      -> load a NOP while a multiply is still in flight
//   otherwise -> load the Execute-stage results
// The CC register only updates on the same edge that really loads an OPQ.
module pipe_execute_stage
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_W  = 4,
    parameter int STAT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        Execute_icode,
    input  logic [3:0]        Execute_ifun,
    input  logic [REG_W-1:0]  Execute_dstE,
    input  logic [REG_W-1:0]  Execute_dstM,
    input  logic [REG_W-1:0]  Execute_srcA,
    input  logic [REG_W-1:0]  Execute_srcB,
    input  logic [DATA_W-1:0] Execute_valA,
    input  logic [DATA_W-1:0] Execute_valB,
    input  logic [DATA_W-1:0] Execute_valC,
    input  logic [STAT_W-1:0] Execute_stat,
    input  logic [STAT_W-1:0] memory_stat,
    input  logic [STAT_W-1:0] Write_stat,
    input  logic              M_stall,
    input  logic              M_bubble,
    output logic [DATA_W-1:0] execute_valE,
    output logic [REG_W-1:0]  execute_dstE,
    output logic              execute_cnd,
    output logic              execute_busy,
    output logic [2:0]        cc_flags,
    output logic [3:0]        Memory_icode,
    output logic [REG_W-1:0]  Memory_dstE,
    output logic [REG_W-1:0]  Memory_dstM,
    output logic [DATA_W-1:0] Memory_valE,
    output logic [DATA_W-1:0] Memory_valA,
    output logic [STAT_W-1:0] Memory_stat,
    output logic              Memory_cnd
);

    localparam logic [REG_W-1:0]  REG_NONE = '1;
    localparam logic [STAT_W-1:0] AOK      = STAT_W'(STAT_AOK);
    localparam logic [DATA_W-1:0] STEP     = DATA_W'(DATA_W / 8);

    logic [DATA_W-1:0] op_res;
    logic              op_of;
    logic              op_valid;
    logic              set_cc;
    logic              em_load;
    logic              cond_raw;

    // Source register IDs are consumed by forwarding logic elsewhere
    logic unused_src;
    assign unused_src = ^{Execute_srcA, Execute_srcB};

`ifdef MULQ_EN
    localparam int CNT_W = $clog2(DATA_W);

    mul_state_t        mul_state, mul_next;
    logic [DATA_W-1:0] mul_acc, mul_mcand, mul_mplier;
    logic [CNT_W-1:0]  mul_cnt;
    logic              mul_start;

    assign mul_start = (mul_state == MUL_IDLE) && (Execute_icode == I_OPQ) &&
                       (Execute_ifun == ALU_MUL) && (Execute_stat == AOK);
    assign execute_busy = mul_start || (mul_state == MUL_BUSY);

    // Multiplier state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mul_state <= MUL_IDLE;
        else     mul_state <= mul_next;
    end

    // Multiplier next state: one BUSY clock per multiplier bit, then DONE
    // until the result actually leaves through the E->M register
    always_comb begin
        mul_next = mul_state;
        case (mul_state)
            MUL_IDLE: if (mul_start) mul_next = MUL_BUSY;
            MUL_BUSY: if (mul_cnt == CNT_W'(DATA_W - 1)) mul_next = MUL_DONE;
            MUL_DONE: if (M_bubble || !M_stall) mul_next = MUL_IDLE;
            default:  mul_next = MUL_IDLE;
        endcase
    end

    // Shift-add datapath; low DATA_W product bits are sign-agnostic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
        end else if (mul_state == MUL_IDLE) begin
            if (mul_start) begin
                mul_acc    <= '0;
                mul_mcand  <= Execute_valA;
                mul_mplier <= Execute_valB;
                mul_cnt    <= '0;
            end
        end else if (mul_state == MUL_BUSY) begin
            if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt + CNT_W'(1);
        end
    end
`else
    assign execute_busy = 1'b0;
`endif

    // ALU result, overflow and function-code validity
    always_comb begin
        op_res   = '0;
        op_of    = 1'b0;
        op_valid = 1'b0;
        case (Execute_ifun)
            ALU_ADD: begin
                op_res   = Execute_valB + Execute_valA;
                op_of    = (Execute_valA[DATA_W-1] == Execute_valB[DATA_W-1]) &&
                           (op_res[DATA_W-1] != Execute_valA[DATA_W-1]);
                op_valid = 1'b1;
            end
            ALU_SUB: begin
                op_res   = Execute_valB - Execute_valA;
                op_of    = (Execute_valA[DATA_W-1] != Execute_valB[DATA_W-1]) &&
                           (op_res[DATA_W-1] != Execute_valB[DATA_W-1]);
                op_valid = 1'b1;
            end
            ALU_AND: begin
                op_res   = Execute_valB & Execute_valA;
                op_valid = 1'b1;
            end
            ALU_XOR: begin
                op_res   = Execute_valB ^ Execute_valA;
                op_valid = 1'b1;
            end
`ifdef MULQ_EN
            ALU_MUL: begin
                op_res   = (mul_state == MUL_DONE) ? mul_acc : '0;
                op_valid = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign set_cc  = (Execute_icode == I_OPQ) && op_valid && (Execute_stat == AOK) &&
                     (memory_stat == AOK) && (Write_stat == AOK);
    assign em_load = !M_bubble && !M_stall && !execute_busy;

    // Condition-code register, written only as the OPQ moves into E->M
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cc_flags <= CC_RESET;
        else if (set_cc && em_load)
            cc_flags <= {(op_res == '0), op_res[DATA_W-1], op_of};
    end

    // valE selection by instruction class
    always_comb begin
        execute_valE = '0;
        case (Execute_icode)
            I_IRMOVQ:           execute_valE = Execute_valC;
            I_RRMOVQ, I_JXX:    execute_valE = Execute_valA;
            I_RMMOVQ, I_MRMOVQ: execute_valE = Execute_valB + Execute_valC;
            I_CALL, I_PUSHQ:    execute_valE = Execute_valB - STEP;
            I_RET, I_POPQ:      execute_valE = Execute_valB + STEP;
            I_OPQ:              execute_valE = op_res;
            default:            execute_valE = '0;
        endcase
    end

    y86_cond_eval u_cond (
        .ifun (Execute_ifun),
        .cc   (cc_flags),
        .cnd  (cond_raw)
    );

    assign execute_cnd  = ((Execute_icode == I_RRMOVQ) || (Execute_icode == I_JXX)) && cond_raw;
    assign execute_dstE = ((Execute_icode == I_RRMOVQ) && !execute_cnd) ? REG_NONE : Execute_dstE;

    // E->M pipeline register with bubble/stall/busy control
    always_ff @(posedge clk or posedge rst) begin
        if (rst || M_bubble || (!M_stall && execute_busy)) begin
            Memory_icode <= I_NOP;
            Memory_dstE  <= REG_NONE;
            Memory_dstM  <= REG_NONE;
            Memory_valE  <= '0;
            Memory_valA  <= '0;
            Memory_stat  <= AOK;
            Memory_cnd   <= 1'b0;
        end else if (em_load) begin
            Memory_icode <= Execute_icode;
            Memory_dstE  <= execute_dstE;
            Memory_dstM  <= Execute_dstM;
            Memory_valE  <= execute_valE;
            Memory_valA  <= Execute_valA;
            Memory_stat  <= Execute_stat;
            Memory_cnd   <= execute_cnd;
        end
    end

endmodule

// File: tb/tb_pipe_execute_stage.sv
// Testbench for pipe_execute_stage (DATA_W=64). Multiply tests are built
// only when MULQ_EN is defined, matching the DUT build.
module tb_pipe_execute_stage;
    import y86_pkg::*;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    Execute_icode, Execute_ifun;
    logic [3:0]    Execute_dstE, Execute_dstM, Execute_srcA, Execute_srcB;
    logic [DW-1:0] Execute_valA, Execute_valB, Execute_valC;
    logic [3:0]    Execute_stat, memory_stat, Write_stat;
    logic          M_stall, M_bubble;
    logic [DW-1:0] execute_valE;
    logic [3:0]    execute_dstE;
    logic          execute_cnd, execute_busy;
    logic [2:0]    cc_flags;
    logic [3:0]    Memory_icode, Memory_dstE, Memory_dstM, Memory_stat;
    logic [DW-1:0] Memory_valE, Memory_valA;
    logic          Memory_cnd;

    typedef struct packed {
        logic [3:0]    icode;
        logic [3:0]    dste;
        logic [3:0]    dstm;
        logic [DW-1:0] vale;
        logic [DW-1:0] vala;
        logic [3:0]    stat;
        logic          cnd;
        logic [2:0]    cc;
    } em_t;

    em_t exp_q[$];
    em_t last_em;
    int  checks = 0;
    int  errors = 0;

    pipe_execute_stage #(.DATA_W(DW), .REG_W(4), .STAT_W(4)) dut (
        .clk(clk), .rst(rst),
        .Execute_icode(Execute_icode), .Execute_ifun(Execute_ifun),
        .Execute_dstE(Execute_dstE), .Execute_dstM(Execute_dstM),
        .Execute_srcA(Execute_srcA), .Execute_srcB(Execute_srcB),
        .Execute_valA(Execute_valA), .Execute_valB(Execute_valB), .Execute_valC(Execute_valC),
        .Execute_stat(Execute_stat), .memory_stat(memory_stat), .Write_stat(Write_stat),
        .M_stall(M_stall), .M_bubble(M_bubble),
        .execute_valE(execute_valE), .execute_dstE(execute_dstE),
        .execute_cnd(execute_cnd), .execute_busy(execute_busy), .cc_flags(cc_flags),
        .Memory_icode(Memory_icode), .Memory_dstE(Memory_dstE), .Memory_dstM(Memory_dstM),
        .Memory_valE(Memory_valE), .Memory_valA(Memory_valA),
        .Memory_stat(Memory_stat), .Memory_cnd(Memory_cnd)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: E->M register and CC are compared after every edge that has an expectation
    initial begin
        em_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mem_icode", Memory_icode, e.icode);
                check("mem_dstE",  Memory_dstE,  e.dste);
                check("mem_dstM",  Memory_dstM,  e.dstm);
                check("mem_valE",  Memory_valE,  e.vale);
                check("mem_valA",  Memory_valA,  e.vala);
                check("mem_stat",  Memory_stat,  e.stat);
                check("mem_cnd",   Memory_cnd,   e.cnd);
                check("cc_flags",  cc_flags,     e.cc);
            end
        end
    end

    task automatic present(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] de,
                           input logic [3:0] dm, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c);
        Execute_icode = ic;
        Execute_ifun  = fn;
        Execute_dstE  = de;
        Execute_dstM  = dm;
        Execute_srcA  = 4'h1;
        Execute_srcB  = 4'h2;
        Execute_valA  = a;
        Execute_valB  = b;
        Execute_valC  = c;
        Execute_stat  = STAT_AOK;
    endtask

    task automatic push_nop(input logic [2:0] ecc);
        em_t e;
        e = '{icode: I_NOP, dste: 4'hF, dstm: 4'hF, vale: '0, vala: '0,
              stat: STAT_AOK, cnd: 1'b0, cc: ecc};
        exp_q.push_back(e);
    endtask

    // Present one instruction at a negedge, check combinational outputs,
    // queue the expected E->M contents and CC after the next edge.
    task automatic step_op(input string nm, input logic [3:0] ic, input logic [3:0] fn,
                           input logic [3:0] de, input logic [3:0] dm,
                           input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                           input logic [DW-1:0] ev, input logic [3:0] ed, input logic ec,
                           input logic [2:0] ecc);
        present(ic, fn, de, dm, a, b, c);
        #1;
        check({nm, "_valE"}, execute_valE, ev);
        check({nm, "_dstE"}, execute_dstE, ed);
        check({nm, "_cnd"},  execute_cnd,  ec);
        last_em = '{icode: ic, dste: ed, dstm: dm, vale: ev, vala: a,
                    stat: STAT_AOK, cnd: ec, cc: ecc};
        exp_q.push_back(last_em);
        @(negedge clk);
    endtask

`ifdef MULQ_EN
    task automatic run_mul(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] ev,
                           input logic [2:0] cc_busy, input logic [2:0] cc_done);
        int n;
        n = 0;
        present(I_OPQ, ALU_MUL, 4'h7, 4'hF, a, b, '0);
        for (int k = 0; k < 200; k++) begin
            #1;
            if (!execute_busy) break;
            n++;
            push_nop(cc_busy);
            @(negedge clk);
        end
        check("mul_busy_clks", n, DW + 1);
        check("mul_valE", execute_valE, ev);
        last_em = '{icode: I_OPQ, dste: 4'h7, dstm: 4'hF, vale: ev, vala: a,
                    stat: STAT_AOK, cnd: 1'b0, cc: cc_done};
        exp_q.push_back(last_em);
        @(negedge clk);
    endtask
`endif

    // Stimulus
    initial begin
        rst = 1'b1;
        memory_stat = STAT_AOK;
        Write_stat  = STAT_AOK;
        M_stall  = 1'b0;
        M_bubble = 1'b0;
        present(I_NOP, 4'h0, 4'hF, 4'hF, '0, '0, '0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_icode", Memory_icode, I_NOP);
        check("rst_dstE",  Memory_dstE, 4'hF);
        check("rst_dstM",  Memory_dstM, 4'hF);
        check("rst_valE",  Memory_valE, '0);
        check("rst_valA",  Memory_valA, '0);
        check("rst_stat",  Memory_stat, STAT_AOK);
        check("rst_cnd",   Memory_cnd, 1'b0);
        check("rst_cc",    cc_flags, 3'b100);
        check("rst_busy",  execute_busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // ALU and condition codes
        step_op("sub",  I_OPQ, ALU_SUB, 4'h2, 4'hF, 64'd5, 64'd3, '0,
                64'hFFFF_FFFF_FFFF_FFFE, 4'h2, 1'b0, 3'b010);
        step_op("jl",   I_JXX, C_L,  4'hF, 4'hF, 64'h40, '0, 64'h99, 64'h40, 4'hF, 1'b1, 3'b010);
        step_op("jge",  I_JXX, C_GE, 4'hF, 4'hF, 64'h44, '0, 64'h99, 64'h44, 4'hF, 1'b0, 3'b010);
        step_op("addv", I_OPQ, ALU_ADD, 4'h3, 4'hF, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, '0,
                64'h8000_0000_0000_0000, 4'h3, 1'b0, 3'b011);
        memory_stat = STAT_ADR;
        step_op("add_madr", I_OPQ, ALU_ADD, 4'h3, 4'hF, '0, '0, '0, '0, 4'h3, 1'b0, 3'b011);
        memory_stat = STAT_AOK;
        Write_stat  = STAT_HLT;
        step_op("xor_whlt", I_OPQ, ALU_XOR, 4'h3, 4'hF, 64'h5, 64'h5, '0, '0, 4'h3, 1'b0, 3'b011);
        Write_stat  = STAT_AOK;
        step_op("and",  I_OPQ, ALU_AND, 4'h4, 4'hF, 64'hF0, 64'h3C, '0, 64'h30, 4'h4, 1'b0, 3'b000);
        step_op("xor",  I_OPQ, ALU_XOR, 4'h4, 4'hF, 64'h55, 64'h55, '0, '0, 4'h4, 1'b0, 3'b100);

        // Conditional moves with ZF=1
        step_op("cmovne", I_RRMOVQ, C_NE, 4'h5, 4'hF, 64'h1234, '0, '0, 64'h1234, 4'hF, 1'b0, 3'b100);
        step_op("cmove",  I_RRMOVQ, C_E,  4'h5, 4'hF, 64'h1234, '0, '0, 64'h1234, 4'h5, 1'b1, 3'b100);

        // Address and stack arithmetic
        step_op("pushq",  I_PUSHQ,  4'h0, 4'h4, 4'hF, 64'h77, 64'h100, '0, 64'hF8, 4'h4, 1'b0, 3'b100);
        step_op("popq",   I_POPQ,   4'h0, 4'h4, 4'h6, 64'h77, 64'h100, '0, 64'h108, 4'h4, 1'b0, 3'b100);
        step_op("call",   I_CALL,   4'h0, 4'h4, 4'hF, 64'h10, 64'h200, 64'h300, 64'h1F8, 4'h4, 1'b0, 3'b100);
        step_op("ret",    I_RET,    4'h0, 4'h4, 4'hF, 64'h10, 64'h1F8, '0, 64'h200, 4'h4, 1'b0, 3'b100);
        step_op("mrmovq", I_MRMOVQ, 4'h0, 4'hF, 4'h3, 64'h10, 64'h1000, 64'h20, 64'h1020, 4'hF, 1'b0, 3'b100);
        step_op("halt",   I_HALT,   4'h0, 4'hF, 4'hF, 64'h10, 64'h1000, 64'h20, '0, 4'hF, 1'b0, 3'b100);
        step_op("irmovq", I_IRMOVQ, 4'h0, 4'h6, 4'hF, 64'h9, '0, 64'hAB, 64'hAB, 4'h6, 1'b0, 3'b100);

        // Stall holds E->M and CC for two clocks
        M_stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            present(I_OPQ, ALU_ADD, 4'h2, 4'hF, 64'd1, 64'd1, '0);
            #1;
            check("stall_valE", execute_valE, 64'd2);
            exp_q.push_back(last_em);
            @(negedge clk);
        end

        // Bubble wins over stall
        M_bubble = 1'b1;
        present(I_OPQ, ALU_ADD, 4'h2, 4'hF, 64'd1, 64'd1, '0);
        push_nop(3'b100);
        @(negedge clk);
        M_stall  = 1'b0;
        M_bubble = 1'b0;

        step_op("add",    I_OPQ, ALU_ADD, 4'h2, 4'hF, 64'd1, 64'd1, '0, 64'd2, 4'h2, 1'b0, 3'b000);
        step_op("opq_f7", I_OPQ, 4'h7, 4'h2, 4'hF, '0, '0, '0, '0, 4'h2, 1'b0, 3'b000);

`ifdef MULQ_EN
        run_mul(64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 3'b000, 3'b010);
        // Reset in the middle of a multiply
        present(I_OPQ, ALU_MUL, 4'h7, 4'hF, 64'd3, 64'd3, '0);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("mul2_busy", execute_busy, 1'b1);
            push_nop(3'b010);
            @(negedge clk);
        end
        present(I_NOP, 4'h0, 4'hF, 4'hF, '0, '0, '0);
        rst = 1'b1;
        #1;
        check("mulrst_busy",  execute_busy, 1'b0);
        check("mulrst_icode", Memory_icode, I_NOP);
        check("mulrst_cc",    cc_flags, 3'b100);
        @(negedge clk);
        rst = 1'b0;
        run_mul(64'd2, 64'd5, 64'd10, 3'b100, 3'b000);
`else
        step_op("opq_f4", I_OPQ, ALU_MUL, 4'h2, 4'hF, '0, '0, '0, '0, 4'h2, 1'b0, 3'b000);
`endif

        // Asynchronous reset mid-stream
        present(I_OPQ, ALU_SUB, 4'h2, 4'h3, 64'd5, 64'd3, '0);
        rst = 1'b1;
        #1;
        check("midrst_icode", Memory_icode, I_NOP);
        check("midrst_dstE",  Memory_dstE, 4'hF);
        check("midrst_dstM",  Memory_dstM, 4'hF);
        check("midrst_cc",    cc_flags, 3'b100);
        @(negedge clk);
        rst = 1'b0;
        step_op("je_after_rst", I_JXX, C_E, 4'hF, 4'hF, 64'h80, '0, '0, 64'h80, 4'hF, 1'b1, 3'b100);

        // Drain the scoreboard
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
